// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states
// and the byte-lane write-enable helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Misaligned or illegal sizes never reach the array, so lane 3 halves are moot.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << lane;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [3:0]         we_i,
  input  logic [31:0]        wdata_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [2**DEPTH_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for the core's data port: decodes RV32I access size,
// checks alignment and range, inserts wait states and pulses READY once.
module dmem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_W     = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        READY,
  output logic        ERR,
  output logic [1:0]  state_o
);

  // Handshake: REQ is sampled only in IDLE; the access is latched on that
  // edge and READY is a single-cycle pulse, with ERR/RDATA valid only then.

  localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_W;

  dmem_state_t        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, err_q;
  logic [2:0]         f3_q;
  logic [1:0]         lane_q;
  logic [DEPTH_W-1:0] idx_q;
  logic [31:0]        wdata_q;

  logic [31:0]        offset;
  logic [DEPTH_W-1:0] idx_in, rd_idx;
  logic               fault_in, accept;
  logic [31:0]        wdata_rep, rd_word, shifted, load_val;
  logic [3:0]         mem_we;

  assign offset = ADDR - BASE_ADDR;
  assign idx_in = offset[DEPTH_W+1:2];
  assign accept = (state_q == ST_IDLE) && REQ;

  always_comb begin
    fault_in = 1'b0;
    case (FUNCT3)
      F3_B:    fault_in = 1'b0;
      F3_H:    fault_in = ADDR[0];
      F3_W:    fault_in = |ADDR[1:0];
      F3_BU:   fault_in = WE;
      F3_HU:   fault_in = WE | ADDR[0];
      default: fault_in = 1'b1;
    endcase
    if ((ADDR < BASE_ADDR) || ({1'b0, offset} >= MEM_BYTES)) fault_in = 1'b1;
  end

  always_comb begin
    case (FUNCT3)
      F3_B:    wdata_rep = {4{WDATA[7:0]}};
      F3_H:    wdata_rep = {2{WDATA[15:0]}};
      default: wdata_rep = WDATA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (REQ) begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= WE;
        err_q   <= fault_in;
        f3_q    <= FUNCT3;
        lane_q  <= ADDR[1:0];
        idx_q   <= idx_in;
        wdata_q <= wdata_rep;
      end
    end
  end

  // With no wait states the read must launch from the live address in IDLE.
  assign rd_idx = (state_q == ST_IDLE) ? idx_in : idx_q;
  assign mem_we = (state_q == ST_RESP && we_q && !err_q) ? byte_en(f3_q, lane_q) : 4'b0000;

  dmem_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk_i   (CLK),
    .waddr_i (idx_q),
    .we_i    (mem_we),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (rd_word)
  );

  always_comb begin
    shifted = rd_word >> {lane_q, 3'b000};
    case (f3_q)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_val = {24'd0, shifted[7:0]};
      F3_HU:   load_val = {16'd0, shifted[15:0]};
      default: load_val = rd_word;
    endcase
  end

  assign READY   = (state_q == ST_RESP);
  assign ERR     = READY && err_q;
  assign RDATA   = (READY && !err_q && !we_q) ? load_val : 32'd0;
  assign state_o = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with no wait states and one with three,
// checked against a byte-addressed reference memory through a response queue.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  import riscv_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1;
  logic [1:0]  st0, st1;

  dmem_ctrl #(.DEPTH_W(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .CLK(clk), .RESET_N(rst_n[0]), .REQ(req[0]), .WE(we[0]), .FUNCT3(f3[0]),
    .ADDR(addr[0]), .WDATA(wdata[0]), .RDATA(rdata0), .READY(ready0), .ERR(err0),
    .state_o(st0)
  );

  dmem_ctrl #(.DEPTH_W(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .CLK(clk), .RESET_N(rst_n[1]), .REQ(req[1]), .WE(we[1]), .FUNCT3(f3[1]),
    .ADDR(addr[1]), .WDATA(wdata[1]), .RDATA(rdata1), .READY(ready1), .ERR(err1),
    .state_o(st1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic get_ready(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction
  function automatic logic [1:0] get_state(input int d);
    return (d == 0) ? st0 : st1;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] mdl [2][4096];

  // Returns {err, rdata}; applies stores to the byte array.
  function automatic logic [32:0] model(input int d, input logic w, input logic [2:0] f,
                                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned size;
    logic [31:0] v, m;
    bit bad;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    bad = (f == 3'd3) || (f >= 3'd6) || (w && (f == 3'd4 || f == 3'd5)) ||
          ((a % size) != 0) || (a >= 32'd4096);
    if (bad) return {1'b1, 32'h0};
    if (w) begin
      for (int i = 0; i < int'(size); i++) mdl[d][a + i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = 32'h0;
    for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mdl[d][a + i];
    if (f < 3'd4 && size < 4) begin
      m = (32'h1 << (8 * size)) - 32'h1;
      if (v[8*size-1]) v = v | ~m;
    end
    return {1'b0, v};
  endfunction

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];

  always @(negedge clk) begin
    logic [64:0] e;
    bit have;
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] && get_ready(d)) begin
        have = 1'b0;
        e = '0;
        if (d == 0) begin
          if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        end else begin
          if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        end
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_ready dut%0d cyc=%0d", d, cyc);
        end else if ({get_err(d), get_rdata(d), cyc} !== e) begin
          errors++;
          $display("FAIL resp dut%0d got err=%0b rdata=%h cyc=%0d exp err=%0b rdata=%h cyc=%0d",
                   d, get_err(d), get_rdata(d), cyc, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the edge ending READY.
  task automatic do_access(input int d, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic [32:0] r;
    logic [31:0] c;
    bit seen;
    r = model(d, w, f, a, wd);
    c = cyc + 32'd1 + ((d == 0) ? 32'd0 : 32'd3);
    if (d == 0) exp_q0.push_back({r, c});
    else        exp_q1.push_back({r, c});
    req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd;
    if (!hold) begin
      @(posedge clk); #1;
      req[d] = 1'b0; we[d] = 1'($urandom); f3[d] = 3'($urandom);
      addr[d] = $urandom; wdata[d] = $urandom;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (get_ready(d)) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d addr=%h got no READY exp READY", d, a);
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    checks++;
    if (get_ready(d) !== 1'b0 || get_err(d) !== 1'b0 || get_rdata(d) !== 32'h0 ||
        get_state(d) !== ST_IDLE) begin
      errors++;
      $display("FAIL %s dut%0d got ready=%b err=%b rdata=%h state=%0d exp 0/0/0/%0d",
               tag, d, get_ready(d), get_err(d), get_rdata(d), get_state(d), ST_IDLE);
    end
  endtask

  task automatic rand_access(input int d);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'd4096 + $urandom_range(0, 15);
      1:       a = 32'hFFFF_FFFC;
      default: a = $urandom_range(0, 127);
    endcase
    do_access(d, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, bit'($urandom_range(0, 1)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'd0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 32; w++) do_access(d, 1'b1, F3_W, 32'(w * 4), $urandom, 1'b1);

    // No wait states: directed cases.
    do_access(0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b1);
    do_access(0, 1'b0, F3_W,  32'h10, 32'h0, 1'b1);
    do_access(0, 1'b1, F3_W,  32'h10, 32'h11223344, 1'b0);
    do_access(0, 1'b1, F3_B,  32'h13, 32'h00000080, 1'b1);
    do_access(0, 1'b0, F3_B,  32'h13, 32'h0, 1'b1);
    do_access(0, 1'b0, F3_BU, 32'h13, 32'h0, 1'b0);
    do_access(0, 1'b0, F3_W,  32'h10, 32'h0, 1'b1);
    do_access(0, 1'b1, F3_W,  32'h20, 32'h0, 1'b1);
    do_access(0, 1'b1, F3_H,  32'h22, 32'h0000BEEF, 1'b1);
    do_access(0, 1'b0, F3_H,  32'h22, 32'h0, 1'b1);
    do_access(0, 1'b0, F3_HU, 32'h22, 32'h0, 1'b1);
    do_access(0, 1'b0, F3_W,  32'h20, 32'h0, 1'b1);
    do_access(0, 1'b0, F3_W,  32'h11, 32'h0, 1'b1);
    do_access(0, 1'b1, F3_H,  32'h21, 32'hFFFFFFFF, 1'b1);
    do_access(0, 1'b1, 3'd3,  32'h10, 32'hFFFFFFFF, 1'b1);
    do_access(0, 1'b1, F3_W,  32'd4096, 32'hFFFFFFFF, 1'b1);
    do_access(0, 1'b1, F3_BU, 32'h10, 32'hFFFFFFFF, 1'b1);
    do_access(0, 1'b0, F3_W,  32'h10, 32'h0, 1'b1);
    do_access(0, 1'b0, F3_W,  32'h20, 32'h0, 1'b1);
    repeat (60) rand_access(0);

    // Three wait states: latency, back-to-back and dropped REQ.
    do_access(1, 1'b1, F3_W,  32'h40, 32'hCAFEF00D, 1'b1);
    do_access(1, 1'b0, F3_W,  32'h40, 32'h0, 1'b1);
    do_access(1, 1'b0, F3_H,  32'h42, 32'h0, 1'b0);
    do_access(1, 1'b0, F3_B,  32'h41, 32'h0, 1'b1);
    repeat (40) rand_access(1);

    // Reset pulsed during WAIT of a store: it must not land.
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = F3_W; addr[1] = 32'h30; wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    check_quiet(1, "mid_reset");
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_access(1, 1'b0, F3_W, 32'h30, 32'h0, 1'b1);
    do_access(1, 1'b0, F3_HU, 32'h32, 32'h0, 1'b1);

    repeat (4) @(posedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d/%0d pending exp 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
